// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry constants and FSM state type for the VGA tile prefetcher
package vga_pkg;
   localparam int SUPER_COLS = 20;
   localparam int SUPER_ROWS = 15;
   localparam int PIC_W      = 9;
   localparam int ADDR_W     = 16;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/vga_line_buf.sv
// vga_line_buf: double-banked superpixel line store with a back-bank write port and a registered front-bank read port
//   clk_i, rst_ni                            : clock, sync active-low reset (clears the read register only)
//   wr_en_i, wr_bank_i, wr_col_i, wr_data_i  : back-bank write
//   rd_bank_i, rd_x_i, rd_data_o             : front-bank read, one-cycle latency, 0 when rd_x_i >= COLS
module vga_line_buf
   import vga_pkg::*;
#(
   parameter int COLS = SUPER_COLS
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic             wr_bank_i,
   input  logic [4:0]       wr_col_i,
   input  logic [PIC_W-1:0] wr_data_i,
   input  logic             rd_bank_i,
   input  logic [4:0]       rd_x_i,
   output logic [PIC_W-1:0] rd_data_o
);
   localparam logic [4:0] LAST = 5'(COLS - 1);
   logic [PIC_W-1:0] bank_q [2][COLS];
   logic [PIC_W-1:0] rd_q, rd_d;
   assign rd_d      = rd_x_i <= LAST ? bank_q[rd_bank_i][rd_x_i] : '0;
   assign rd_data_o = rd_q;
   always_ff @(posedge clk_i) begin
      if (wr_en_i) bank_q[wr_bank_i][wr_col_i] <= wr_data_i;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) rd_q <= '0;
      else rd_q <= rd_d;
   end
endmodule

// File: rtl/vga_tile_prefetch.sv
// vga_tile_prefetch: fetches one superpixel row of picture numbers from main memory into a double-buffered line store
//   clk, rst                                     : 50 MHz clock, sync active-low reset
//   start_addr, row_len, fetch_row, fetch_go     : fill request, sampled when accepted in IDLE
//   swap                                         : exchange front/back buffers, deferred to DONE while busy
//   rd_x, pic_num                                : front-buffer column read, registered, 0 for rd_x >= COLS
//   mem_addr, mem_en, mem_data                   : memory read port, data arrives RD_LAT cycles after each strobe
//   busy, done, underrun                         : status; underrun is a sticky swap-while-busy flag only when
//                                                  VGA_PREFETCH_UNDERRUN_EN is defined, otherwise constant 0
module vga_tile_prefetch
   import vga_pkg::*;
#(
   parameter int COLS   = SUPER_COLS,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] row_len,
   input  logic [3:0]        fetch_row,
   input  logic              fetch_go,
   input  logic              swap,
   input  logic [4:0]        rd_x,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   input  logic [ADDR_W-1:0] mem_data,
   output logic [PIC_W-1:0]  pic_num,
   output logic              busy,
   output logic              done,
   output logic              underrun
);
   localparam logic [4:0] LAST = 5'(COLS - 1);
   state_t            state_q, state_d;
   logic [4:0]        col_q, col_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              fsel_q, fsel_d, pend_q, pend_d;
   logic [RD_LAT-1:0] vld_q;
   logic [4:0]        pcol_q [RD_LAT];
   logic              issue, wr_en, toggle, unused_hi;
   logic [4:0]        wr_col;
   assign issue     = state_q == ISSUE;
   assign busy      = issue || state_q == DRAIN;
   assign done      = state_q == DONE;
   assign mem_en    = issue;
   assign mem_addr  = issue ? base_q + ADDR_W'(col_q) : '0;
   assign wr_en     = vld_q[RD_LAT-1];
   assign wr_col    = pcol_q[RD_LAT-1];
   assign unused_hi = ^mem_data[ADDR_W-1:PIC_W];
   // a swap during a fill is held until DONE so the front never shows a partial row; pending and new swap merge
   assign toggle    = (state_q == IDLE && swap) || (done && (swap || pend_q));
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = fetch_go ? ISSUE : IDLE;
         ISSUE:   state_d = col_q == LAST ? DRAIN : ISSUE;
         DRAIN:   state_d = wr_en && wr_col == LAST ? DONE : DRAIN;
         default: state_d = IDLE;
      endcase
      col_d  = issue && col_q != LAST ? col_q + 5'd1 : '0;
      base_d = state_q == IDLE && fetch_go ? start_addr + {12'd0, fetch_row} * row_len : base_q;
      fsel_d = fsel_q ^ toggle;
      pend_d = !done && (pend_q || (busy && swap));
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         base_q  <= '0;
         fsel_q  <= 1'b0;
         pend_q  <= 1'b0;
         vld_q   <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         base_q   <= base_d;
         fsel_q   <= fsel_d;
         pend_q   <= pend_d;
         vld_q[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end
   // column index travels alongside each outstanding read until its data returns
   always_ff @(posedge clk) begin
      pcol_q[0] <= col_q;
      for (int i = 1; i < RD_LAT; i++) pcol_q[i] <= pcol_q[i-1];
   end
`ifdef VGA_PREFETCH_UNDERRUN_EN
   logic under_q;
   always_ff @(posedge clk) begin
      if (!rst) under_q <= 1'b0;
      else if (busy && swap) under_q <= 1'b1;
   end
   assign underrun = under_q;
`else
   assign underrun = 1'b0;
`endif
   vga_line_buf #(.COLS(COLS)) u_buf (
      .clk_i     (clk),
      .rst_ni    (rst),
      .wr_en_i   (wr_en),
      .wr_bank_i (~fsel_q),
      .wr_col_i  (wr_col),
      .wr_data_i (mem_data[PIC_W-1:0]),
      .rd_bank_i (fsel_q),
      .rd_x_i    (rd_x),
      .rd_data_o (pic_num)
   );
endmodule
